// File: rtl/settable_clock.sv
// rtl/settable_clock.sv - settable time-of-day clock: prescaler, s/m/h counters, load, fast-set, 12h decode
module settable_clock #(
    parameter int SYS_CLK_HZ = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int DIV_W      = 26
) (
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [4:0] i_load_hours,
    input  logic [5:0] i_load_minutes,
    input  logic [5:0] i_load_seconds,
    input  logic       i_inc_hours,
    input  logic       i_inc_minutes,
    input  logic       i_clr_seconds,
    output logic [5:0] o_seconds,
    output logic [5:0] o_minutes,
    output logic [4:0] o_hours,
    output logic [3:0] o_hours_12,
    output logic       o_pm,
    output logic       o_sec_tick,
    output logic       o_load_err
);

    localparam int DIV = SYS_CLK_HZ / TICK_HZ;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_presc;
    logic [5:0]       r_seconds;
    logic [5:0]       r_minutes;
    logic [4:0]       r_hours;
    logic             r_sec_tick;
    logic             r_load_err;

    logic w_tick;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hr_wrap;
    logic w_min_carry;
    logic w_hr_carry;
    logic w_bad_h;
    logic w_bad_m;
    logic w_bad_s;
    logic [3:0] w_hours_12;

    // A clear pre-empts the tick, so no seconds carry can ripple on that edge.
    assign w_tick      = i_en && (r_presc == DIV_LAST) && !i_clr_seconds;
    assign w_sec_wrap  = (r_seconds == 6'd59);
    assign w_min_wrap  = (r_minutes == 6'd59);
    assign w_hr_wrap   = (r_hours == 5'd23);
    assign w_min_carry = w_tick && w_sec_wrap;
    assign w_hr_carry  = w_min_carry && w_min_wrap;

    assign w_bad_h = (i_load_hours   >= 5'd24);
    assign w_bad_m = (i_load_minutes >= 6'd60);
    assign w_bad_s = (i_load_seconds >= 6'd60);

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_presc    <= '0;
            r_seconds  <= '0;
            r_minutes  <= '0;
            r_hours    <= '0;
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
            if (i_load) begin
                r_presc    <= '0;
                r_hours    <= w_bad_h ? 5'd0 : i_load_hours;
                r_minutes  <= w_bad_m ? 6'd0 : i_load_minutes;
                r_seconds  <= w_bad_s ? 6'd0 : i_load_seconds;
                r_load_err <= w_bad_h || w_bad_m || w_bad_s;
            end else begin
                if (i_clr_seconds) begin
                    r_seconds <= '0;
                    r_presc   <= '0;
                end else if (w_tick) begin
                    r_presc    <= '0;
                    r_sec_tick <= 1'b1;
                    r_seconds  <= w_sec_wrap ? 6'd0 : r_seconds + 6'd1;
                end else if (i_en) begin
                    r_presc <= r_presc + 1'b1;
                end

                // Fast-set overrides ripple: the field moves by exactly one.
                if (i_inc_minutes || w_min_carry) begin
                    r_minutes <= w_min_wrap ? 6'd0 : r_minutes + 6'd1;
                end

                if (i_inc_hours || (w_hr_carry && !i_inc_minutes)) begin
                    r_hours <= w_hr_wrap ? 5'd0 : r_hours + 5'd1;
                end
            end
        end
    end

    always_comb begin
        w_hours_12 = 4'd12;
        if (r_hours == 5'd0 || r_hours == 5'd12) begin
            w_hours_12 = 4'd12;
        end else if (r_hours > 5'd12) begin
            w_hours_12 = 4'(r_hours - 5'd12);
        end else begin
            w_hours_12 = r_hours[3:0];
        end
    end

    assign o_seconds  = r_seconds;
    assign o_minutes  = r_minutes;
    assign o_hours    = r_hours;
    assign o_hours_12 = w_hours_12;
    assign o_pm       = (r_hours >= 5'd12);
    assign o_sec_tick = r_sec_tick;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_settable_clock.sv
// tb/tb_settable_clock.sv - randomized + directed check of settable_clock against a seconds-of-day model
module tb_settable_clock;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [4:0] lh = '0;
    logic [5:0] lm = '0;
    logic [5:0] ls = '0;
    logic       inc_h = 1'b0;
    logic       inc_m = 1'b0;
    logic       clr_s = 1'b0;
    logic [5:0] o_seconds;
    logic [5:0] o_minutes;
    logic [4:0] o_hours;
    logic [3:0] o_hours_12;
    logic       o_pm;
    logic       o_sec_tick;
    logic       o_load_err;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  checking = 1'b0;

    settable_clock #(.SYS_CLK_HZ(4), .TICK_HZ(1), .DIV_W(3)) dut (
        .i_sysclk      (clk),
        .i_reset       (rst),
        .i_en          (en),
        .i_load        (load),
        .i_load_hours  (lh),
        .i_load_minutes(lm),
        .i_load_seconds(ls),
        .i_inc_hours   (inc_h),
        .i_inc_minutes (inc_m),
        .i_clr_seconds (clr_s),
        .o_seconds     (o_seconds),
        .o_minutes     (o_minutes),
        .o_hours       (o_hours),
        .o_hours_12    (o_hours_12),
        .o_pm          (o_pm),
        .o_sec_tick    (o_sec_tick),
        .o_load_err    (o_load_err)
    );

    always #5 clk = ~clk;

    // Model: time held as seconds-of-day, prescaler as a plain count.
    typedef struct {
        int t;
        int p;
        bit tk;
        bit er;
    } mstate_t;

    int m_t = 0;
    int m_p = 0;
    bit m_tk = 1'b0;
    bit m_er = 1'b0;

    function automatic mstate_t model_next(int t, int p);
        mstate_t r;
        int h, m, s, nh, nm, ns, nt;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        nh = h; nm = m; ns = s;
        r.p = p; r.tk = 1'b0; r.er = 1'b0;
        if (load) begin
            nh = (int'(lh) < 24) ? int'(lh) : 0;
            nm = (int'(lm) < 60) ? int'(lm) : 0;
            ns = (int'(ls) < 60) ? int'(ls) : 0;
            r.er = (int'(lh) >= 24) || (int'(lm) >= 60) || (int'(ls) >= 60);
            r.p = 0;
        end else begin
            if (clr_s) begin
                ns = 0;
                r.p = 0;
            end else if (en && p == DIV - 1) begin
                nt = (t + 1) % 86400;
                nh = nt / 3600; nm = (nt / 60) % 60; ns = nt % 60;
                r.p = 0;
                r.tk = 1'b1;
            end else if (en) begin
                r.p = p + 1;
            end
            if (inc_m) begin
                nm = (m + 1) % 60;
                nh = h;
            end
            if (inc_h) nh = (h + 1) % 24;
        end
        r.t = nh * 3600 + nm * 60 + ns;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        mstate_t nx;
        if (rst) begin
            m_t <= 0; m_p <= 0; m_tk <= 1'b0; m_er <= 1'b0;
        end else begin
            nx = model_next(m_t, m_p);
            m_t <= nx.t; m_p <= nx.p; m_tk <= nx.tk; m_er <= nx.er;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int h;
        if (checking) begin
            h = m_t / 3600;
            chk("cyc_hours",   int'(o_hours),    h);
            chk("cyc_minutes", int'(o_minutes),  (m_t / 60) % 60);
            chk("cyc_seconds", int'(o_seconds),  m_t % 60);
            chk("cyc_h12",     int'(o_hours_12), (h % 12 == 0) ? 12 : h % 12);
            chk("cyc_pm",      int'(o_pm),       int'(h >= 12));
            chk("cyc_tick",    int'(o_sec_tick), int'(m_tk));
            chk("cyc_lderr",   int'(o_load_err), int'(m_er));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load = 1'b1; lh = 5'(h); lm = 6'(m); ls = 6'(s);
        step();
        load = 1'b0;
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk({name, "_h"}, int'(o_hours), h);
        chk({name, "_m"}, int'(o_minutes), m);
        chk({name, "_s"}, int'(o_seconds), s);
        chk({name, "_model"}, m_t, h * 3600 + m * 60 + s);
    endtask

    initial begin
        #2 rst = 1'b1;
        step();
        step();
        checking = 1'b1;
        chk_time("reset", 0, 0, 0);
        chk("reset_h12", int'(o_hours_12), 12);
        chk("reset_pm", int'(o_pm), 0);
        chk("reset_tick", int'(o_sec_tick), 0);
        chk("reset_err", int'(o_load_err), 0);

        // First tick four edges after release, then every four.
        en = 1'b1;
        rst = 1'b0;
        repeat (3) step();
        chk("first_tick_early", int'(o_sec_tick), 0);
        step();
        chk("first_tick", int'(o_sec_tick), 1);
        chk("first_sec", int'(o_seconds), 1);
        repeat (3) step();
        chk("second_tick_early", int'(o_sec_tick), 0);
        step();
        chk("second_tick", int'(o_sec_tick), 1);
        chk("second_sec", int'(o_seconds), 2);

        // Midnight rollover.
        do_load(23, 59, 58);
        chk_time("ld_2359", 23, 59, 58);
        repeat (4) step();
        chk_time("pre_midnight", 23, 59, 59);
        chk("pre_midnight_pm", int'(o_pm), 1);
        chk("pre_midnight_h12", int'(o_hours_12), 11);
        repeat (4) step();
        chk_time("midnight", 0, 0, 0);
        chk("midnight_pm", int'(o_pm), 0);
        chk("midnight_h12", int'(o_hours_12), 12);

        // Out-of-range load.
        do_load(24, 30, 61);
        chk_time("bad_load", 0, 30, 0);
        chk("bad_load_err", int'(o_load_err), 1);
        step();
        chk("bad_load_err_clr", int'(o_load_err), 0);

        // Fast-set minutes on the tick edge drops the seconds carry.
        do_load(10, 59, 59);
        repeat (3) step();
        inc_m = 1'b1;
        step();
        inc_m = 1'b0;
        chk_time("inc_min_tick", 10, 0, 0);
        chk("inc_min_tick_strobe", int'(o_sec_tick), 1);
        do_load(23, 10, 0);
        inc_h = 1'b1;
        step();
        inc_h = 1'b0;
        chk_time("inc_hr_wrap", 0, 10, 0);

        // Enable low freezes; then clear restarts the prescaler.
        do_load(13, 5, 7);
        en = 1'b0;
        repeat (20) step();
        chk_time("frozen", 13, 5, 7);
        chk("frozen_h12", int'(o_hours_12), 1);
        chk("frozen_pm", int'(o_pm), 1);
        en = 1'b1;
        repeat (2) step();
        clr_s = 1'b1;
        step();
        clr_s = 1'b0;
        chk_time("cleared", 13, 5, 0);
        repeat (3) step();
        chk("clr_restart_early", int'(o_seconds), 0);
        step();
        chk("clr_restart_tick", int'(o_seconds), 1);

        // Asynchronous reset mid-prescaler.
        do_load(12, 34, 56);
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        chk_time("async_rst", 0, 0, 0);
        chk("async_rst_h12", int'(o_hours_12), 12);
        chk("async_rst_pm", int'(o_pm), 0);
        step();
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            load  = ($urandom_range(0, 49) == 0);
            lh    = 5'($urandom_range(0, 31));
            lm    = 6'($urandom_range(0, 63));
            ls    = 6'($urandom_range(0, 63));
            clr_s = ($urandom_range(0, 29) == 0);
            inc_h = ($urandom_range(0, 19) == 0);
            inc_m = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0; clr_s = 1'b0; inc_h = 1'b0; inc_m = 1'b0;
        step();
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/settable_clock.md
Name: settable_clock

Overview:
- Parametrised, settable time-of-day clock: prescaler plus cascaded seconds/minutes/hours counters with carry ripple.
- Adds parallel load, per-field fast-set increment, seconds clear, 12-hour display outputs, a one-second tick strobe and load range checking.
- Sits between the top-level button/UART control logic and the display encoder.
- Replaces the fixed-rate, non-settable counter chain in the current clock.

Parameters:
- SYS_CLK_HZ, 50_000_000, system clock frequency in Hz; prescaler divide ratio DIV = SYS_CLK_HZ / TICK_HZ, minimum 2.
- TICK_HZ, 1, rate at which seconds advance; the bench uses values > 1 for accelerated runs.
- DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= DIV.

Ports:
- i_sysclk, in, 1, system clock; all state updates on the rising edge.
- i_reset, in, 1, reset; asynchronous, active-high.
- i_en, in, 1, count enable; gates the prescaler only.
- i_load, in, 1, single-cycle load strobe.
- i_load_hours, in, 5, hours value to load (0-23).
- i_load_minutes, in, 6, minutes value to load (0-59).
- i_load_seconds, in, 6, seconds value to load (0-59).
- i_inc_hours, in, 1, fast-set: increment hours once per asserted cycle.
- i_inc_minutes, in, 1, fast-set: increment minutes once per asserted cycle.
- i_clr_seconds, in, 1, clear seconds and prescaler.
- o_seconds, out, 6, seconds 0-59.
- o_minutes, out, 6, minutes 0-59.
- o_hours, out, 5, hours 0-23 (24-hour).
- o_hours_12, out, 4, 12-hour display hours 1-12.
- o_pm, out, 1, high when o_hours >= 12.
- o_sec_tick, out, 1, one-cycle pulse coincident with each seconds advance.
- o_load_err, out, 1, one-cycle pulse when a load contained any out-of-range field.

Behaviour:
- Reset: prescaler=0, o_seconds=0, o_minutes=0, o_hours=0, o_sec_tick=0, o_load_err=0.
  - Derived outputs during reset: o_hours_12=12, o_pm=0.
  - Reset mid-count discards all state immediately; no partial carry survives.
- Prescaler:
  - Counts 0..DIV-1 while i_en=1 and holds while i_en=0.
  - Tick condition: i_en=1 and prescaler==DIV-1.
  - On tick, the prescaler wraps to 0 and seconds advance at the same edge.
- Counters:
  - seconds 59->0 generates a carry into minutes on the same edge.
  - minutes 59->0 with an incoming carry generates a carry into hours on the same edge.
  - hours 23->0 wraps and carries nowhere.
  - 23:59:59 plus one tick becomes 00:00:00 at a single edge.
- o_sec_tick: registered; high in exactly the cycle in which the new seconds value is first visible; never high while i_en=0.
- Priority per edge, highest first: i_reset > i_load > i_clr_seconds > i_inc_* > tick counting.
- i_load:
  - Writes all three fields and clears the prescaler; the tick is suppressed that cycle.
  - Any field out of range (hours>=24, minutes>=60, seconds>=60) is written as 0; in-range fields load normally.
  - o_load_err pulses high on the cycle after that edge.
  - All inc/clr inputs are ignored on a load cycle.
- i_clr_seconds:
  - Sets seconds=0 and prescaler=0; no tick and no carry that cycle.
  - i_inc_hours and i_inc_minutes still apply on the same edge.
- i_inc_minutes:
  - Increments minutes by exactly 1 per cycle asserted, wrapping 59->0 with no carry into hours.
  - A seconds carry arriving on the same edge is dropped, so minutes change by exactly 1.
  - Seconds and prescaler still advance normally.
- i_inc_hours:
  - Increments hours by 1, wrapping 23->0.
  - A minutes carry on the same edge is dropped.
  - Both inc inputs may be asserted together; each field increments once.
- 12-hour decode: combinational from o_hours.
  - o_hours_12 = 12 when hours is 0 or 12; otherwise hours mod 12.
  - o_pm = (hours >= 12).
- i_en=0 freezes timekeeping; load, clear and inc still operate.

Test Plan:
- Set SYS_CLK_HZ=4, TICK_HZ=1, i_en=1, release reset -> first o_sec_tick on cycle 4 after reset release, with o_seconds=1 in that cycle; o_sec_tick then every 4 cycles.
- Load 23:59:58, then run 8 cycles -> reads 23:59:59, then 00:00:00; o_pm changes 1->0 and o_hours_12 reads 12 at midnight.
- Load hours=24, minutes=30, seconds=61 -> o_hours=0, o_minutes=30, o_seconds=0, o_load_err pulses for one cycle.
- At 10:59:59, assert i_inc_minutes on the tick edge -> 10:00:00 (minutes wrap, no carry, hours stay 10); separately assert i_inc_hours at 23 -> 0.
- Hold i_en=0 for 20 cycles at 13:05:07 -> no change and no o_sec_tick; o_hours_12=1 and o_pm=1; i_clr_seconds -> 13:05:00 with prescaler restarted.
- Assert i_reset asynchronously mid-prescaler at 12:34:56 -> all outputs return to reset values before the next clock edge.
